// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the synchronous ROM and queues {instr, pc} pairs.
// Build option FETCH_SKID_EN selects a two-entry queue (1 instr/cycle); default is one entry.
module fetch_unit #(
  parameter  int unsigned ROM_SIZE = 8,
  parameter  int unsigned INSTR_W  = 11,
  localparam int unsigned ADDR_W   = $clog2(ROM_SIZE)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               rom_en,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               redir_valid,
  input  logic [ADDR_W-1:0]  redir_addr
);

`ifdef FETCH_SKID_EN
  localparam int unsigned DEPTH = 2;
`else
  localparam int unsigned DEPTH = 1;
`endif
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] issued_pc_q, issued_pc_d;
  logic              inflight_q, inflight_d;
  logic              drop_q, drop_d;
  logic [CNT_W-1:0]  count_q, count_d;
  entry_t            entry_q [DEPTH];
  entry_t            entry_d [DEPTH];

  logic              pop;
  logic              push;
  logic [CNT_W:0]    occupancy;
  logic [CNT_W-1:0]  wr_idx;

  assign out_valid = !rst && (count_q != '0);
  assign pop       = out_valid && out_ready;

  // Slots committed after this cycle: queued + response arriving - entry leaving.
  assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
  assign rom_en    = !rst && !redir_valid && (occupancy < (CNT_W + 1)'(DEPTH));
  assign rom_addr  = pc_q;

  assign push      = inflight_q && !drop_q && !redir_valid;
  assign wr_idx    = count_q - CNT_W'(pop);

  assign out_instr = entry_q[0].instr;
  assign out_pc    = entry_q[0].pc;

  always_comb begin
    pc_d        = pc_q;
    issued_pc_d = issued_pc_q;
    inflight_d  = rom_en;
    // A read issued alongside a redirect would be stale; the issue rule prevents it today.
    drop_d      = rom_en && redir_valid;
    count_d     = count_q;

    if (rom_en) begin
      pc_d        = pc_q + 1'b1;
      issued_pc_d = pc_q;
    end

    if (redir_valid) begin
      pc_d    = redir_addr;
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Shift-down queue: entry 0 is always the head, stale slots are left untouched.
    for (int i = 0; i < int'(DEPTH); i++) begin
      entry_d[i] = entry_q[i];
      if (pop && ((i + 1) < int'(count_q))) begin
        entry_d[i] = entry_q[(i + 1) % int'(DEPTH)];
      end
      if (push && (CNT_W'(i) == wr_idx)) begin
        entry_d[i] = '{instr: rom_data, pc: issued_pc_q};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= '0;
      issued_pc_q <= '0;
      inflight_q  <= 1'b0;
      drop_q      <= 1'b0;
      count_q     <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      pc_q        <= pc_d;
      issued_pc_q <= issued_pc_d;
      inflight_q  <= inflight_d;
      drop_q      <= drop_d;
      count_q     <= count_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

endmodule
